logic_issue_stage: RTL and testbench
====================================

LOGIC_ISSUE_STAGE -- requirements
Module: logic_issue_stage

Interface
REQ-001 Parameter: DEPTH, default 4, number of request FIFO entries (power of two, 2..16).
REQ-002 Parameter: W, default 32, operand and result width.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 in_valid  input  1  request strobe.
REQ-006 in_ready  output  1  stage can accept a request this cycle.
REQ-007 in_op  input  3  logic operation code, 000..111.
REQ-008 in_a  input  W  operand A.
REQ-009 in_b  input  W  operand B.
REQ-010 lu_op  output  3  operation code driven to the combinational logic unit.
REQ-011 lu_a  output  W  operand A driven to the logic unit.
REQ-012 lu_b  output  W  operand B driven to the logic unit.
REQ-013 lu_c  input  W  combinational result returned by the logic unit.
REQ-014 res_valid  output  1  result register holds an unconsumed result.
REQ-015 res_ready  input  1  consumer accepts the result this cycle.
REQ-016 res_data  output  W  registered result.
REQ-017 res_op  output  3  operation code that produced res_data.
REQ-018 count  output  $clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-019 Push: in_valid && in_ready at a rising edge writes {in_op,in_a,in_b} at the write pointer, and the write pointer increments modulo DEPTH.
REQ-020 in_ready = (count < DEPTH), with no same-cycle pop bypass: when full, in_ready is 0 even if a pop occurs in that cycle.
REQ-021 lu_op/lu_a/lu_b are driven combinationally from the FIFO head entry when count > 0, and are 0 when the FIFO is empty.
REQ-022 Pop/capture condition: count > 0 && (!res_valid || res_ready).
REQ-023 On the pop/capture condition at a rising edge: res_data <= lu_c; res_op <= head op; res_valid <= 1; read pointer increments modulo DEPTH.
REQ-024 res_valid && res_ready with no pop/capture in the same cycle: res_valid <= 0, and res_data/res_op hold their values.
REQ-025 Results are never overwritten while res_valid=1 && res_ready=0; the FIFO head stalls.
REQ-026 Simultaneous push and pop: count is unchanged and both pointers advance.
REQ-027 Latency: a request pushed at edge N produces res_valid=1 after edge N+1 when the result register is free; throughput is one result per cycle under res_ready=1.
REQ-028 Results leave in request order; no reordering and no dropping.
REQ-029 Both pointers wrap from DEPTH-1 to 0; full and empty are distinguished by count, not by pointer equality.
REQ-030 in_valid while in_ready=0: the request is ignored and no state changes.
REQ-031 Opcode content is not interpreted by this stage; all eight codes pass through unchanged.

Reset
REQ-032 While rst_n=0 at a rising edge: pointers=0, count=0, res_valid=0, res_data=0, res_op=0; therefore in_ready=1 and lu_* = 0 after that edge.
REQ-033 Reset mid-operation discards all queued entries and any pending result; in_valid and res_ready are ignored in the reset cycle.
REQ-034 FIFO storage contents need not be cleared by reset.

Verification
REQ-035 Bench instantiates the 3-bit-opcode logic unit on lu_*/lu_c; push A=0x000000DB, B=0x000000BC with op 000..111 back-to-back, res_ready=1 -> res_data sequence 0x98, 0x67, 0xFFFFFF67, 0xFF, 0xFFFFFF24, 0xFFFFFF00, 0xFFFFFF25, 0xFFFFFF98 with matching res_op, one result per cycle.
REQ-036 res_ready=0, push 5 requests with DEPTH=4 -> first result is captured, the next 4 fill the FIFO (count=4, in_ready=0), and the 6th push is ignored; then res_ready=1 -> all 5 results drain in order.
REQ-037 Full FIFO with res_ready=1 and in_valid=1 held -> in_ready=0 in the full cycle, then recovers to 1 next cycle; no entry is lost or duplicated.
REQ-038 Pointer wrap: stream 10 requests through DEPTH=4 under random res_ready -> output order equals input order and count never exceeds 4.
REQ-039 Assert rst_n=0 with count=3 and res_valid=1 -> next cycle res_valid=0, count=0, in_ready=1, lu_a=0; a subsequent push yields only the new result.
REQ-040 Single request into an idle stage -> lu_a equals in_a one cycle after the push, and res_valid rises one cycle after that.

Source files
------------

// File: rtl/logic_issue_stage_if.sv
// Bundle of request, logic-unit and result signals around the logic issue stage.
// Handshake: a transfer happens at a rising edge where valid && ready are both 1; ready never waits on valid.
interface logic_issue_stage_if #(
    parameter int DEPTH = 4,
    parameter int W     = 32
);
    logic                     in_valid;
    logic                     in_ready;
    logic [2:0]               in_op;
    logic [W-1:0]             in_a;
    logic [W-1:0]             in_b;
    logic [2:0]               lu_op;
    logic [W-1:0]             lu_a;
    logic [W-1:0]             lu_b;
    logic [W-1:0]             lu_c;
    logic                     res_valid;
    logic                     res_ready;
    logic [W-1:0]             res_data;
    logic [2:0]               res_op;
    logic [$clog2(DEPTH):0]   count;

    modport master (
        output in_valid, in_op, in_a, in_b, lu_c, res_ready,
        input  in_ready, lu_op, lu_a, lu_b, res_valid, res_data, res_op, count
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, lu_c, res_ready,
        output in_ready, lu_op, lu_a, lu_b, res_valid, res_data, res_op, count
    );
endinterface

// File: rtl/logic_issue_stage.sv
// Request FIFO feeding an external combinational logic unit, with a one-entry
// result register that holds its value until the consumer takes it.
module logic_issue_stage #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    logic_issue_stage_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
    localparam logic [CW-1:0] C_ONE   = CW'(1);
    localparam logic [AW-1:0] P_ONE   = AW'(1);

    logic [2:0]    r_mem_op [DEPTH];
    logic [W-1:0]  r_mem_a  [DEPTH];
    logic [W-1:0]  r_mem_b  [DEPTH];

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_res_valid;
    logic [W-1:0]  r_res_data;
    logic [2:0]    r_res_op;

    logic          w_empty;
    logic          w_in_ready;
    logic          w_push;
    logic          w_pop;

    assign w_empty    = (r_count == '0);
    // Full is judged on the registered count only, so a pop in the full cycle does not open the input.
    assign w_in_ready = (r_count < C_DEPTH);
    assign w_push     = bus.in_valid && w_in_ready;
    assign w_pop      = !w_empty && (!r_res_valid || bus.res_ready);

    assign bus.in_ready  = w_in_ready;
    assign bus.lu_op     = w_empty ? 3'b000 : r_mem_op[r_rd_ptr];
    assign bus.lu_a      = w_empty ? '0     : r_mem_a[r_rd_ptr];
    assign bus.lu_b      = w_empty ? '0     : r_mem_b[r_rd_ptr];
    assign bus.res_valid = r_res_valid;
    assign bus.res_data  = r_res_data;
    assign bus.res_op    = r_res_op;
    assign bus.count     = r_count;

    // Storage is left uncleared; occupancy alone decides what is live.
    always_ff @(posedge clk) begin
        if (rst_n && w_push) begin
            r_mem_op[r_wr_ptr] <= bus.in_op;
            r_mem_a[r_wr_ptr]  <= bus.in_a;
            r_mem_b[r_wr_ptr]  <= bus.in_b;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_op    <= 3'b000;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + P_ONE;
            end
            if (w_pop) begin
                r_rd_ptr    <= r_rd_ptr + P_ONE;
                r_res_data  <= bus.lu_c;
                r_res_op    <= r_mem_op[r_rd_ptr];
                r_res_valid <= 1'b1;
            end else if (r_res_valid && bus.res_ready) begin
                r_res_valid <= 1'b0;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + C_ONE;
                2'b01:   r_count <= r_count - C_ONE;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: tb/tb_logic_issue_stage.sv
// Self-checking bench for logic_issue_stage with a behavioural logic unit and result scoreboard.
`timescale 1ns/1ps
module tb_logic_issue_stage;
    localparam int DEPTH = 4;
    localparam int W     = 32;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic_issue_stage_if #(.DEPTH(DEPTH), .W(W)) bus ();

    logic_issue_stage #(.DEPTH(DEPTH), .W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_total = 0;
    int n_bad   = 0;
    int n_res   = 0;
    int base;
    logic done;
    logic [W-1:0] exp_q[$];
    logic [2:0]   exp_op_q[$];
    logic [W-1:0] tbl[8] = '{32'h0000_0098, 32'h0000_0067, 32'hFFFF_FF67, 32'h0000_00FF,
                             32'hFFFF_FF24, 32'hFFFF_FF00, 32'hFFFF_FF25, 32'hFFFF_FF98};

    function automatic logic [W-1:0] lu_fn(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        case (op)
            3'd0:    return a & b;
            3'd1:    return a ^ b;
            3'd2:    return ~(a & b);
            3'd3:    return a | b;
            3'd4:    return ~a;
            3'd5:    return ~(a | b);
            3'd6:    return -a;
            default: return ~(a ^ b);
        endcase
    endfunction

    always_comb bus.lu_c = lu_fn(bus.lu_op, bus.lu_a, bus.lu_b);

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: sample handshakes mid-cycle, they complete at the following rising edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            exp_op_q.delete();
        end else begin
            chk("occupancy", W'(bus.count) + W'(bus.res_valid), W'(exp_q.size()));
            chk("count_max", W'(32'(bus.count) <= DEPTH), W'(1));
            if (bus.res_valid && bus.res_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", W'(exp_q.size()), W'(1));
                end else begin
                    chk("res_data", bus.res_data, exp_q.pop_front());
                    chk("res_op", W'(bus.res_op), W'(exp_op_q.pop_front()));
                end
                n_res++;
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(lu_fn(bus.in_op, bus.in_a, bus.in_b));
                exp_op_q.push_back(bus.in_op);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.res_ready = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic ok;
        ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_op = op;
        bus.in_a = a;
        bus.in_b = b;
        for (int t = 0; t < 64 && !ok; t++) begin
            @(negedge clk);
            ok = bus.in_ready;
            step();
        end
        bus.in_valid = 1'b0;
        if (!ok) chk("send_timeout", W'(ok), W'(1));
    endtask

    task automatic send_rand();
        send(3'($urandom), $urandom, $urandom);
    endtask

    task automatic drain();
        bus.res_ready = 1'b1;
        for (int t = 0; t < 64 && exp_q.size() != 0; t++) step();
        chk("drain_empty", W'(exp_q.size()), W'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_op = 3'd0;
        bus.in_a = '0;
        bus.in_b = '0;
        bus.res_ready = 1'b0;
        done = 1'b0;
        do_reset();

        @(negedge clk);
        chk("reset_in_ready", W'(bus.in_ready), W'(1));
        chk("reset_count", W'(bus.count), W'(0));
        chk("reset_res_valid", W'(bus.res_valid), W'(0));
        chk("reset_lu_a", bus.lu_a, W'(0));
        chk("reset_lu_op", W'(bus.lu_op), W'(0));
        chk("reset_res_data", bus.res_data, W'(0));
        chk("reset_res_op", W'(bus.res_op), W'(0));
        step();

        // Single request into an idle stage.
        bus.res_ready = 1'b1;
        send(3'd5, 32'h1234_5678, 32'h0F0F_0F0F);
        @(negedge clk);
        chk("single_lu_a", bus.lu_a, 32'h1234_5678);
        chk("single_res_valid_early", W'(bus.res_valid), W'(0));
        step();
        @(negedge clk);
        chk("single_res_valid", W'(bus.res_valid), W'(1));
        chk("single_res_data", bus.res_data, 32'hE0C0_A080);
        step();
        step();

        // All eight opcodes back to back on fixed operands.
        fork
            begin
                for (int i = 0; i < 8; i++) send(3'(i), 32'h0000_00DB, 32'h0000_00BC);
            end
            begin
                for (int k = 0; k < 10; k++) begin
                    @(negedge clk);
                    if (k >= 2) begin
                        chk("ops_valid", W'(bus.res_valid), W'(1));
                        chk("ops_data", bus.res_data, tbl[k-2]);
                        chk("ops_op", W'(bus.res_op), W'(k-2));
                    end
                end
            end
        join
        step();

        // Fill with consumer stalled; extra push must be ignored.
        bus.res_ready = 1'b0;
        base = n_res;
        for (int i = 0; i < 5; i++) send_rand();
        @(negedge clk);
        chk("full_count", W'(bus.count), W'(4));
        chk("full_in_ready", W'(bus.in_ready), W'(0));
        chk("full_res_valid", W'(bus.res_valid), W'(1));
        bus.in_valid = 1'b1;
        bus.in_op = 3'd7;
        bus.in_a = 32'hDEAD_BEEF;
        bus.in_b = 32'h0BAD_F00D;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("full_ignore_ready", W'(bus.in_ready), W'(0));
        end
        bus.in_valid = 1'b0;
        step();
        drain();
        chk("full_drained", W'(n_res - base), W'(5));

        // Full cycle with consumer ready: in_ready recovers one cycle later.
        bus.res_ready = 1'b0;
        base = n_res;
        for (int i = 0; i < 5; i++) send_rand();
        fork
            begin
                bus.res_ready = 1'b1;
                send_rand();
            end
            begin
                @(negedge clk);
                chk("recover_full_ready", W'(bus.in_ready), W'(0));
                chk("recover_full_count", W'(bus.count), W'(4));
                @(negedge clk);
                chk("recover_ready", W'(bus.in_ready), W'(1));
            end
        join
        drain();
        chk("recover_drained", W'(n_res - base), W'(6));

        // Random stream under random back-pressure, wraps the pointers.
        base = n_res;
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 10; i++) send_rand();
                done = 1'b1;
            end
            begin
                while (!done) begin
                    bus.res_ready = 1'($urandom_range(0, 1));
                    step();
                end
            end
        join
        drain();
        chk("stream_drained", W'(n_res - base), W'(10));

        // Reset in the middle of activity.
        bus.res_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_rand();
        @(negedge clk);
        chk("midrst_pre_count", W'(bus.count), W'(3));
        chk("midrst_pre_valid", W'(bus.res_valid), W'(1));
        step();
        rst_n = 1'b0;
        bus.in_valid = 1'b1;
        bus.res_ready = 1'b1;
        step();
        rst_n = 1'b1;
        bus.in_valid = 1'b0;
        bus.res_ready = 1'b0;
        base = n_res;
        @(negedge clk);
        chk("midrst_res_valid", W'(bus.res_valid), W'(0));
        chk("midrst_count", W'(bus.count), W'(0));
        chk("midrst_in_ready", W'(bus.in_ready), W'(1));
        chk("midrst_lu_a", bus.lu_a, W'(0));
        step();
        send(3'd0, 32'h0000_00F0, 32'h0000_003C);
        drain();
        chk("midrst_only_new", W'(n_res - base), W'(1));
        step();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
